// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg
//   Shared definitions for the Gray-conversion arbiter slice:
//   - out_state_e : output-stage occupancy (empty / holding a result)
//   - bin2gray_f  : reference binary-to-Gray function (b ^ (b >> 1)) used by
//                   RTL assertions and by the bench scoreboard. Operates on 32
//                   bits; callers truncate to their data width.
package gray_conv_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic logic [31:0] bin2gray_f(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// bin2gray
//   Purely combinational binary-to-Gray converter.
//   Ports:
//     bin  : binary input  [WIDTH]
//     gray : Gray output   [WIDTH]
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search starts one past the last
//   granted index and wraps modulo NREQ; the first requesting index wins.
//   Ports:
//     req        : per-requester request bits        [NREQ]
//     en         : grant enable (grant forced to 0 when low)
//     last_grant : index granted most recently       [IDW]
//     grant      : one-hot (or zero) grant           [NREQ]
//     grant_idx  : encoded winning index, valid whenever any req is set
//                  (independent of en so the datapath mux can settle early)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic found;

  always_comb begin
    int unsigned k;
    k         = '0;
    found     = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      k = (32'(last_grant) + off) % NREQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant_idx = IDW'(k);
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
//   Shares one bin2gray datapath between NREQ valid/ready requesters using
//   round-robin arbitration. The result sits in a single-entry registered
//   output stage tagged with the served requester index.
//   Ports:
//     clk, rst   : clock (rising edge), asynchronous active-high reset
//     req_valid  : per-requester valid                     [NREQ]
//     req_bin    : packed operands, lane i at [i*WIDTH +: WIDTH]
//     req_ready  : one-hot (or zero) accept strobe          [NREQ]
//     out_valid  : result valid
//     out_ready  : consumer ready
//     out_gray   : Gray-coded result                        [WIDTH]
//     out_bin    : original binary operand                  [WIDTH]
//     out_id     : index of the served requester            [IDW]
//     xfer_cnt   : completed output transfers, wrapping     [CNTW]
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNTW  = 16,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_gray,
  output logic [WIDTH-1:0]      out_bin,
  output logic [IDW-1:0]        out_id,
  output logic [CNTW-1:0]       xfer_cnt
);

  out_state_e       state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [WIDTH-1:0] gray_q, bin_q;
  logic [IDW-1:0]   id_q;
  logic [CNTW-1:0]  cnt_q;

  logic             can_accept;
  logic             accept;
  logic             drain;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_bin, sel_gray;

  assign out_valid  = (state_q == ST_FULL);
  assign drain      = out_valid & out_ready;
  assign can_accept = (state_q == ST_EMPTY) | drain;

  // Reset gating keeps req_ready low while rst is asserted, even though
  // the registered state is already forced to EMPTY.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req        (req_valid),
    .en         (can_accept & ~rst),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_bin   = req_bin[32'(grant_idx) * WIDTH +: WIDTH];

  bin2gray #(
    .WIDTH (WIDTH)
  ) u_b2g (
    .bin  (sel_bin),
    .gray (sel_gray)
  );

  // Accept takes priority so a simultaneous drain and reload stays FULL.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = ST_FULL;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      last_grant_q <= IDW'(NREQ - 1);
      gray_q       <= '0;
      bin_q        <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        gray_q       <= sel_gray;
        bin_q        <= sel_bin;
        id_q         <= grant_idx;
        last_grant_q <= grant_idx;
      end
      if (drain) begin
        cnt_q <= cnt_q + CNTW'(1);
      end
    end
  end

  assign out_gray = gray_q;
  assign out_bin  = bin_q;
  assign out_id   = id_q;
  assign xfer_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(req_ready));
      if (out_valid) begin
        assert (out_gray == WIDTH'(bin2gray_f(32'(out_bin))));
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter
//   Directed bench for gray_conv_arbiter: reset, single requester, round
//   robin, backpressure, exhaustive Gray data and counter wrap (second
//   instance with a 4-bit transfer counter sharing the same stimulus).
module tb_gray_conv_arbiter;
  import gray_conv_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_bin;
  logic                  out_ready;

  logic [NREQ-1:0]  req_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_gray, out_bin;
  logic [IDW-1:0]   out_id;
  logic [15:0]      xfer_cnt;

  logic [NREQ-1:0]  c4_req_ready;
  logic             c4_out_valid;
  logic [WIDTH-1:0] c4_out_gray, c4_out_bin;
  logic [IDW-1:0]   c4_out_id;
  logic [3:0]       c4_xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-computed Gray codes for 0..15.
  logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_conv_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .CNTW  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_bin   (out_bin),
    .out_id    (out_id),
    .xfer_cnt  (xfer_cnt)
  );

  gray_conv_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .CNTW  (4)
  ) dut_c4 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (c4_req_ready),
    .out_valid (c4_out_valid),
    .out_ready (out_ready),
    .out_gray  (c4_out_gray),
    .out_bin   (c4_out_bin),
    .out_id    (c4_out_id),
    .xfer_cnt  (c4_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int q[$];
    int v, recv, exp_v;
    bit acc, drn;

    rst       = 1'b1;
    req_valid = '0;
    req_bin   = '0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_xfer_cnt",  32'(xfer_cnt), 0);
    check("rst_out_gray",  32'(out_gray), 0);
    tick();
    rst = 1'b0;

    // Single requester
    req_valid           = 4'b0001;
    req_bin[0 +: WIDTH] = 4'b1011;
    out_ready           = 1'b1;
    @(negedge clk);
    check("single_req_ready", 32'(req_ready), 32'b0001);
    tick();
    check("single_out_valid", 32'(out_valid), 1);
    check("single_out_gray",  32'(out_gray), 32'b1110);
    check("single_out_bin",   32'(out_bin), 32'b1011);
    check("single_out_id",    32'(out_id), 0);
    check("single_cnt0",      32'(xfer_cnt), 0);
    req_valid = '0;
    tick();
    check("single_drained",   32'(out_valid), 0);
    check("single_cnt1",      32'(xfer_cnt), 1);
    check("single_stale_gray", 32'(out_gray), 32'b1110);

    // Reset mid-transfer
    req_bin   = {4'd8, 4'd7, 4'd6, 4'd5};
    req_valid = 4'b1111;
    out_ready = 1'b0;
    tick();
    check("mid_out_valid", 32'(out_valid), 1);
    check("mid_out_id",    32'(out_id), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_req_ready", 32'(req_ready), 0);
    check("arst_xfer_cnt",  32'(xfer_cnt), 0);
    check("arst_out_id",    32'(out_id), 0);
    check("arst_out_bin",   32'(out_bin), 0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;

    // Round robin, all requesting
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      check($sformatf("rr_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("rr_id_%0d", i), 32'(out_id), 32'(i % 4));
      check($sformatf("rr_bin_%0d", i), 32'(out_bin), 32'(i % 4 + 5));
      check($sformatf("rr_gray_%0d", i), 32'(out_gray), 32'(gtab[i % 4 + 5]));
    end
    // Sparse 1010 after last grant 1 -> 3 then 1
    req_valid = 4'b1010;
    @(negedge clk);
    check("sparse_ready_a", 32'(req_ready), 32'b1000);
    tick();
    check("sparse_id_a", 32'(out_id), 3);
    @(negedge clk);
    check("sparse_ready_b", 32'(req_ready), 32'b0010);
    tick();
    check("sparse_id_b", 32'(out_id), 1);
    check("rr_xfer_cnt", 32'(xfer_cnt), 7);

    // Backpressure
    req_valid = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_ready_%0d", i), 32'(req_ready), 0);
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("bp_id_%0d", i), 32'(out_id), 1);
      check($sformatf("bp_bin_%0d", i), 32'(out_bin), 6);
      check($sformatf("bp_gray_%0d", i), 32'(out_gray), 32'(gtab[6]));
      tick();
    end
    check("bp_cnt_hold", 32'(xfer_cnt), 7);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(req_ready), 32'b0100);
    tick();
    check("bp_nobubble_valid", 32'(out_valid), 1);
    check("bp_reload_id",      32'(out_id), 2);
    check("bp_reload_bin",     32'(out_bin), 7);
    check("bp_cnt_after",      32'(xfer_cnt), 8);
    req_valid = '0;
    tick();
    check("bp_final_empty", 32'(out_valid), 0);
    check("bp_final_cnt",   32'(xfer_cnt), 9);

    // Exhaustive data from requester 2 with random consumer stalls
    v    = 0;
    recv = 0;
    for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
      out_ready           = 1'($urandom_range(0, 1));
      req_valid           = (v < 16) ? 4'b0100 : 4'b0000;
      req_bin[8 +: WIDTH] = 4'(v);
      @(negedge clk);
      acc = req_ready[2];
      drn = out_valid && out_ready;
      if (drn) begin
        exp_v = (q.size() > 0) ? q.pop_front() : -1;
        check($sformatf("ex_bin_%0d", recv), 32'(out_bin), 32'(exp_v));
        check($sformatf("ex_gray_%0d", recv), 32'(out_gray), 32'(gtab[exp_v[3:0]]));
        check($sformatf("ex_gray_fn_%0d", recv), 32'(out_gray), 32'(4'(bin2gray_f(32'(exp_v)))));
        check($sformatf("ex_id_%0d", recv), 32'(out_id), 2);
        recv++;
      end
      if (acc) begin
        q.push_back(v);
        v++;
      end
      tick();
    end
    check("ex_transfers", 32'(recv), 16);
    check("ex_accepts",   32'(v), 16);
    check("ex_cnt",       32'(xfer_cnt), 25);

    // Counter wrap on the CNTW=4 instance
    req_valid = '0;
    rst       = 1'b1;
    tick();
    check("wrap_rst_cnt", 32'(c4_xfer_cnt), 0);
    rst                 = 1'b0;
    req_valid           = 4'b0001;
    req_bin[0 +: WIDTH] = 4'd9;
    out_ready           = 1'b1;
    tick();
    for (int t = 1; t <= 17; t++) begin
      tick();
      if (t == 15) check("wrap_cnt_15", 32'(c4_xfer_cnt), 15);
      if (t == 16) check("wrap_cnt_16", 32'(c4_xfer_cnt), 0);
      if (t == 17) check("wrap_cnt_17", 32'(c4_xfer_cnt), 1);
    end
    check("wrap_main_cnt", 32'(xfer_cnt), 17);
    @(negedge clk);
    check("wrap_c4_ready", 32'(c4_req_ready), 32'b0001);
    check("wrap_c4_valid", 32'(c4_out_valid), 1);
    check("wrap_c4_id",    32'(c4_out_id), 0);
    check("wrap_c4_bin",   32'(c4_out_bin), 9);
    check("wrap_c4_gray",  32'(c4_out_gray), 32'(gtab[9]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
